// File: rtl/cpu_pkg.sv
// Shared types and constants for the 64-bit ARM pipeline: control bundle,
// zero-register index, canonical NOP encoding and hazard FSM states.
package cpu_pkg;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_op;
        logic       set_flags;
    } ctrl_t;

    localparam logic [4:0]  XZR      = 5'd31;
    localparam logic [31:0] NOP_INSN = 32'hD503201F;

    typedef enum logic {HZ_RUN, HZ_HOLD} hz_state_e;

endpackage

// File: rtl/id_ex_hazard_detect.sv
// Load-use and branch-on-load hazard detection with a RUN/HOLD stall FSM.
// Optional saturating stall counters are built when HAZARD_PERF_EN is defined.
module id_ex_hazard_detect
    import cpu_pkg::*;
#(
`ifdef HAZARD_PERF_EN
    parameter int PERF_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [4:0]        id_Rn,
    input  logic [4:0]        id_Rm,
    input  logic [4:0]        id_Rd,
    input  logic              id_uses_Rn,
    input  logic              id_uses_Rm,
    input  logic              id_cbz_or_br,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_Rd,
    input  logic              ex_flush,
`ifdef HAZARD_PERF_EN
    output logic [PERF_W-1:0] perf_lu_stalls,
    output logic [PERF_W-1:0] perf_br_stalls,
`endif
    output logic              stall
);

    hz_state_e r_state;
    hz_state_e w_next;
    logic      w_lde;
    logic      w_lu;
    logic      w_br_ld;

    // A load writing XZR produces nothing a consumer could wait on.
    assign w_lde   = ex_valid & ex_mem_read & (ex_Rd != XZR);
    assign w_lu    = id_valid & w_lde & ~id_cbz_or_br &
                     ((id_uses_Rn & (id_Rn == ex_Rd)) | (id_uses_Rm & (id_Rm == ex_Rd)));
    assign w_br_ld = id_valid & w_lde & id_cbz_or_br & (id_Rd == ex_Rd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= HZ_RUN;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (ex_flush) begin
            w_next = HZ_RUN;
        end else begin
            case (r_state)
                HZ_RUN:  if (w_br_ld) w_next = HZ_HOLD;
                HZ_HOLD: w_next = HZ_RUN;
                default: w_next = HZ_RUN;
            endcase
        end
    end

    always_comb begin
        stall = 1'b0;
        if (!ex_flush) begin
            case (r_state)
                HZ_RUN:  stall = w_lu | w_br_ld;
                HZ_HOLD: stall = 1'b1;
                default: stall = 1'b0;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] r_lu_cnt;
    logic [PERF_W-1:0] r_br_cnt;
    logic              w_lu_stall;
    logic              w_br_stall;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + {{(PERF_W-1){1'b0}}, 1'b1};
    endfunction

    // LU and BR-LD are mutually exclusive, so any other stall cycle is a branch stall.
    assign w_lu_stall = ~ex_flush & (r_state == HZ_RUN) & w_lu;
    assign w_br_stall = stall & ~w_lu_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lu_cnt <= '0;
            r_br_cnt <= '0;
        end else begin
            if (w_lu_stall) r_lu_cnt <= sat_inc(r_lu_cnt);
            if (w_br_stall) r_br_cnt <= sat_inc(r_br_cnt);
        end
    end

    assign perf_lu_stalls = r_lu_cnt;
    assign perf_br_stalls = r_br_cnt;
`endif

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with bubble insertion on stall or flush.
// Define HAZARD_PERF_EN to expose the perf_lu_stalls/perf_br_stalls counters.
module id_ex_stage_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W = 64
`ifdef HAZARD_PERF_EN
    , parameter int PERF_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       id_instruction,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_Rn_data,
    input  logic [DATA_W-1:0] id_Rm_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_Rn,
    input  logic [4:0]        id_Rm,
    input  logic [4:0]        id_Rd,
    input  logic              id_uses_Rn,
    input  logic              id_uses_Rm,
    input  logic              id_cbz_or_br,
    input  ctrl_t             id_ctrl,
    input  logic              ex_flush,
    output logic              ex_valid,
    output logic [31:0]       instruction_ex,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_Rn_data,
    output logic [DATA_W-1:0] ex_Rm_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_Rn,
    output logic [4:0]        ex_Rm,
    output logic [4:0]        ex_Rd,
    output ctrl_t             ex_ctrl,
    output logic              id_ex_reg_write,
`ifdef HAZARD_PERF_EN
    output logic [PERF_W-1:0] perf_lu_stalls,
    output logic [PERF_W-1:0] perf_br_stalls,
`endif
    output logic              pc_write,
    output logic              if_id_write,
    output logic              stall
);

    logic              r_valid;
    logic [31:0]       r_insn;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_Rn_data;
    logic [DATA_W-1:0] r_Rm_data;
    logic [DATA_W-1:0] r_imm;
    logic [4:0]        r_Rn;
    logic [4:0]        r_Rm;
    logic [4:0]        r_Rd;
    ctrl_t             r_ctrl;
    logic              w_stall;
    logic              w_bubble;

    id_ex_hazard_detect
`ifdef HAZARD_PERF_EN
        #(.PERF_W(PERF_W))
`endif
    u_hazard (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_Rn          (id_Rn),
        .id_Rm          (id_Rm),
        .id_Rd          (id_Rd),
        .id_uses_Rn     (id_uses_Rn),
        .id_uses_Rm     (id_uses_Rm),
        .id_cbz_or_br   (id_cbz_or_br),
        .ex_valid       (r_valid),
        .ex_mem_read    (r_ctrl.mem_read),
        .ex_Rd          (r_Rd),
        .ex_flush       (ex_flush),
`ifdef HAZARD_PERF_EN
        .perf_lu_stalls (perf_lu_stalls),
        .perf_br_stalls (perf_br_stalls),
`endif
        .stall          (w_stall)
    );

    assign w_bubble = w_stall | ex_flush;

    // A bubble looks exactly like the reset image so forwarding never matches it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_insn    <= NOP_INSN;
            r_pc      <= '0;
            r_Rn_data <= '0;
            r_Rm_data <= '0;
            r_imm     <= '0;
            r_Rn      <= XZR;
            r_Rm      <= XZR;
            r_Rd      <= XZR;
            r_ctrl    <= '0;
        end else if (w_bubble) begin
            r_valid   <= 1'b0;
            r_insn    <= NOP_INSN;
            r_pc      <= '0;
            r_Rn_data <= '0;
            r_Rm_data <= '0;
            r_imm     <= '0;
            r_Rn      <= XZR;
            r_Rm      <= XZR;
            r_Rd      <= XZR;
            r_ctrl    <= '0;
        end else begin
            r_valid   <= id_valid;
            r_insn    <= id_instruction;
            r_pc      <= id_pc;
            r_Rn_data <= id_Rn_data;
            r_Rm_data <= id_Rm_data;
            r_imm     <= id_imm;
            r_Rn      <= id_Rn;
            r_Rm      <= id_Rm;
            r_Rd      <= id_Rd;
            r_ctrl    <= id_ctrl;
        end
    end

    assign ex_valid        = r_valid;
    assign instruction_ex  = r_insn;
    assign ex_pc           = r_pc;
    assign ex_Rn_data      = r_Rn_data;
    assign ex_Rm_data      = r_Rm_data;
    assign ex_imm          = r_imm;
    assign ex_Rn           = r_Rn;
    assign ex_Rm           = r_Rm;
    assign ex_Rd           = r_Rd;
    assign ex_ctrl         = r_ctrl;
    assign id_ex_reg_write = r_valid & r_ctrl.reg_write;
    assign stall           = w_stall;
    assign pc_write        = ~w_stall;
    assign if_id_write     = ~w_stall;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed hazard scenarios followed by random traffic
// against a cycle-level reference model of the ID/EX slot and stall rules.
module tb_id_ex_stage_reg;
    import cpu_pkg::*;

    localparam int DATA_W = 64;
`ifdef HAZARD_PERF_EN
    localparam int PERF_W = 4;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [31:0]       id_instruction;
    logic [DATA_W-1:0] id_pc, id_Rn_data, id_Rm_data, id_imm;
    logic [4:0]        id_Rn, id_Rm, id_Rd;
    logic              id_uses_Rn, id_uses_Rm, id_cbz_or_br;
    ctrl_t             id_ctrl;
    logic              ex_flush;
    logic              ex_valid;
    logic [31:0]       instruction_ex;
    logic [DATA_W-1:0] ex_pc, ex_Rn_data, ex_Rm_data, ex_imm;
    logic [4:0]        ex_Rn, ex_Rm, ex_Rd;
    ctrl_t             ex_ctrl;
    logic              id_ex_reg_write, pc_write, if_id_write, stall;
`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_lu_stalls, perf_br_stalls;
`endif

    always #5 clk = ~clk;

    id_ex_stage_reg #(
        .DATA_W(DATA_W)
`ifdef HAZARD_PERF_EN
        , .PERF_W(PERF_W)
`endif
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instruction(id_instruction),
        .id_pc(id_pc), .id_Rn_data(id_Rn_data), .id_Rm_data(id_Rm_data), .id_imm(id_imm),
        .id_Rn(id_Rn), .id_Rm(id_Rm), .id_Rd(id_Rd), .id_uses_Rn(id_uses_Rn),
        .id_uses_Rm(id_uses_Rm), .id_cbz_or_br(id_cbz_or_br), .id_ctrl(id_ctrl),
        .ex_flush(ex_flush), .ex_valid(ex_valid), .instruction_ex(instruction_ex),
        .ex_pc(ex_pc), .ex_Rn_data(ex_Rn_data), .ex_Rm_data(ex_Rm_data), .ex_imm(ex_imm),
        .ex_Rn(ex_Rn), .ex_Rm(ex_Rm), .ex_Rd(ex_Rd), .ex_ctrl(ex_ctrl),
        .id_ex_reg_write(id_ex_reg_write),
`ifdef HAZARD_PERF_EN
        .perf_lu_stalls(perf_lu_stalls), .perf_br_stalls(perf_br_stalls),
`endif
        .pc_write(pc_write), .if_id_write(if_id_write), .stall(stall)
    );

    localparam ctrl_t C_LDUR = '{reg_write: 1'b1, mem_read: 1'b1, mem_write: 1'b0, mem_to_reg: 1'b1,
                                 alu_src: 1'b1, alu_op: 4'h2, set_flags: 1'b0};
    localparam ctrl_t C_ADD  = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0,
                                 alu_src: 1'b0, alu_op: 4'h2, set_flags: 1'b0};
    localparam ctrl_t C_STUR = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b1, mem_to_reg: 1'b0,
                                 alu_src: 1'b1, alu_op: 4'h2, set_flags: 1'b0};
    localparam ctrl_t C_CBZ  = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0,
                                 alu_src: 1'b0, alu_op: 4'h7, set_flags: 1'b0};

    // Reference model: contents of the EX slot, remaining forced stall cycles, stall tallies.
    logic              m_valid;
    ctrl_t             m_ctrl;
    logic [4:0]        m_rn, m_rm, m_rd;
    logic [31:0]       m_insn;
    logic [DATA_W-1:0] m_pc, m_a, m_b, m_imm;
    int                m_hold;
    int                m_lu_cnt, m_br_cnt;
    logic              m_last_stall;
    int                n_chk = 0;
    int                n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_ctrl = '0; m_rn = 5'd31; m_rm = 5'd31; m_rd = 5'd31;
        m_insn = 32'hD503201F; m_pc = '0; m_a = '0; m_b = '0; m_imm = '0;
        m_hold = 0; m_lu_cnt = 0; m_br_cnt = 0; m_last_stall = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ex_valid"}, 64'(ex_valid), 64'(0));
        chk({tag, "_insn"}, 64'(instruction_ex), 64'h00000000D503201F);
        chk({tag, "_ctrl"}, 64'(ex_ctrl), 64'(0));
        chk({tag, "_Rn"}, 64'(ex_Rn), 64'(31));
        chk({tag, "_Rm"}, 64'(ex_Rm), 64'(31));
        chk({tag, "_Rd"}, 64'(ex_Rd), 64'(31));
        chk({tag, "_pc"}, ex_pc, 64'(0));
        chk({tag, "_a"}, ex_Rn_data | ex_Rm_data | ex_imm, 64'(0));
        chk({tag, "_regwr"}, 64'(id_ex_reg_write), 64'(0));
        chk({tag, "_stall"}, 64'(stall), 64'(0));
`ifdef HAZARD_PERF_EN
        chk({tag, "_perf"}, 64'({perf_lu_stalls, perf_br_stalls}), 64'(0));
`endif
    endtask

    task automatic check_ex();
        chk("ex_valid", 64'(ex_valid), 64'(m_valid));
        chk("instruction_ex", 64'(instruction_ex), 64'(m_insn));
        chk("ex_ctrl", 64'(ex_ctrl), 64'(m_ctrl));
        chk("ex_Rd", 64'(ex_Rd), 64'(m_rd));
        chk("id_ex_reg_write", 64'(id_ex_reg_write), 64'(m_valid & m_ctrl.reg_write));
        if (m_valid) begin
            chk("ex_pc", ex_pc, m_pc);
            chk("ex_Rn_data", ex_Rn_data, m_a);
            chk("ex_Rm_data", ex_Rm_data, m_b);
            chk("ex_imm", ex_imm, m_imm);
            chk("ex_Rn_Rm", 64'({ex_Rn, ex_Rm}), 64'({m_rn, m_rm}));
        end
`ifdef HAZARD_PERF_EN
        chk("perf_lu", 64'(perf_lu_stalls), 64'(m_lu_cnt));
        chk("perf_br", 64'(perf_br_stalls), 64'(m_br_cnt));
`endif
    endtask

    task automatic set_id(input logic v, input logic [31:0] insn, input logic [4:0] rn,
                          input logic [4:0] rm, input logic [4:0] rd, input logic urn,
                          input logic urm, input logic cbz, input ctrl_t c);
        id_valid = v; id_instruction = insn; id_Rn = rn; id_Rm = rm; id_Rd = rd;
        id_uses_Rn = urn; id_uses_Rm = urm; id_cbz_or_br = cbz; id_ctrl = c;
        id_pc = {$urandom(), $urandom()}; id_Rn_data = {$urandom(), $urandom()};
        id_Rm_data = {$urandom(), $urandom()}; id_imm = {$urandom(), $urandom()};
    endtask

    // Called at posedge+1 with inputs applied; checks stall mid-cycle, then the EX slot after the edge.
    task automatic step();
        logic lde, lu, br, s;
        int   sat;
        #3;
        lde = m_valid && m_ctrl.mem_read && (m_rd != 5'd31);
        lu  = id_valid && lde && !id_cbz_or_br &&
              ((id_uses_Rn && id_Rn == m_rd) || (id_uses_Rm && id_Rm == m_rd));
        br  = id_valid && lde && id_cbz_or_br && (id_Rd == m_rd);
        s   = !ex_flush && (m_hold > 0 || lu || br);
        chk("stall", 64'(stall), 64'(s));
        chk("pc_write", 64'(pc_write), 64'(!s));
        chk("if_id_write", 64'(if_id_write), 64'(!s));
        @(posedge clk);
        #1;
`ifdef HAZARD_PERF_EN
        sat = (1 << PERF_W) - 1;
`else
        sat = 32'h7FFFFFFF;
`endif
        if (s) begin
            if (m_hold == 0 && lu) m_lu_cnt = (m_lu_cnt == sat) ? m_lu_cnt : m_lu_cnt + 1;
            else                   m_br_cnt = (m_br_cnt == sat) ? m_br_cnt : m_br_cnt + 1;
        end
        if (ex_flush)        m_hold = 0;
        else if (m_hold > 0) m_hold = m_hold - 1;
        else if (br)         m_hold = 1;
        if (s || ex_flush) begin
            m_valid = 1'b0; m_ctrl = '0; m_rd = 5'd31; m_insn = 32'hD503201F;
        end else begin
            m_valid = id_valid; m_ctrl = id_ctrl; m_rd = id_Rd; m_rn = id_Rn; m_rm = id_Rm;
            m_insn = id_instruction; m_pc = id_pc; m_a = id_Rn_data; m_b = id_Rm_data;
            m_imm = id_imm;
        end
        m_last_stall = s;
        check_ex();
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd1;
            1:       return 5'd2;
            2:       return 5'd31;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        rst = 1'b0;
        ex_flush = 1'b0;
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, '0);
        model_reset();
        #12;
        check_reset("rst");
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Load-use: LDUR X1 then ADD X2,X1,X3
        set_id(1'b1, 32'hF8400041, 5'd2, 5'd31, 5'd1, 1'b1, 1'b0, 1'b0, C_LDUR); step();
        set_id(1'b1, 32'h8B030022, 5'd1, 5'd3, 5'd2, 1'b1, 1'b1, 1'b0, C_ADD);  step();
        chk("lu_bubble", 64'(ex_valid), 64'(0));
        step();
        chk("lu_add_in_ex", 64'(instruction_ex), 64'h8B030022);

        // Branch on load: LDUR X4 then CBZ X4 (two stall cycles)
        set_id(1'b1, 32'hF8400044, 5'd2, 5'd31, 5'd4, 1'b1, 1'b0, 1'b0, C_LDUR); step();
        set_id(1'b1, 32'hB4000084, 5'd31, 5'd31, 5'd4, 1'b0, 1'b0, 1'b1, C_CBZ); step(); step(); step();
        chk("brld_cbz_in_ex", 64'(instruction_ex), 64'hB4000084);

        // ALU producer feeding CBZ: no stall
        set_id(1'b1, 32'h8B030025, 5'd1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b0, C_ADD);  step();
        set_id(1'b1, 32'hB4000085, 5'd31, 5'd31, 5'd5, 1'b0, 1'b0, 1'b1, C_CBZ); step();

        // XZR load never stalls; STUR source Rt matches load
        set_id(1'b1, 32'hF840005F, 5'd2, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, C_LDUR); step();
        set_id(1'b1, 32'h8B1F03E2, 5'd31, 5'd3, 5'd2, 1'b1, 1'b1, 1'b0, C_ADD);  step();
        set_id(1'b1, 32'hF8400041, 5'd2, 5'd31, 5'd1, 1'b1, 1'b0, 1'b0, C_LDUR); step();
        set_id(1'b1, 32'hF80000A1, 5'd5, 5'd1, 5'd31, 1'b1, 1'b1, 1'b0, C_STUR); step(); step();

        // Flush while in HOLD
        set_id(1'b1, 32'hF8400044, 5'd2, 5'd31, 5'd4, 1'b1, 1'b0, 1'b0, C_LDUR); step();
        set_id(1'b1, 32'hB4000084, 5'd31, 5'd31, 5'd4, 1'b0, 1'b0, 1'b1, C_CBZ); step();
        ex_flush = 1'b1; step();
        ex_flush = 1'b0; step();

        // Reset asserted in the middle of HOLD
        set_id(1'b1, 32'hF8400044, 5'd2, 5'd31, 5'd4, 1'b1, 1'b0, 1'b0, C_LDUR); step();
        set_id(1'b1, 32'hB4000084, 5'd31, 5'd31, 5'd4, 1'b0, 1'b0, 1'b1, C_CBZ); step();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_reset("rst_hold");
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_reset("rst_hold2");
        step();

        // Twenty load-use stalls in a row
        for (int i = 0; i < 20; i++) begin
            set_id(1'b1, 32'hF8400041, 5'd2, 5'd31, 5'd1, 1'b1, 1'b0, 1'b0, C_LDUR); step();
            set_id(1'b1, 32'h8B030022, 5'd1, 5'd3, 5'd2, 1'b1, 1'b1, 1'b0, C_ADD);  step(); step();
        end
`ifdef HAZARD_PERF_EN
        chk("perf_lu_saturated", 64'(perf_lu_stalls), 64'hF);
`endif

        // Random traffic; IF/ID is held while the model reports a stall
        for (int i = 0; i < 400; i++) begin
            if (!m_last_stall) begin
                case ($urandom_range(0, 3))
                    0: set_id(1'b1, $urandom(), pick_reg(), 5'd31, pick_reg(), 1'b1, 1'b0, 1'b0, C_LDUR);
                    1: set_id(1'b1, $urandom(), pick_reg(), pick_reg(), pick_reg(), 1'b1, 1'b1, 1'b0, C_ADD);
                    2: set_id(1'b1, $urandom(), pick_reg(), pick_reg(), 5'd31, 1'b1, 1'b1, 1'b0, C_STUR);
                    default: set_id(1'b1, $urandom(), 5'd31, 5'd31, pick_reg(), 1'b0, 1'b0, 1'b1, C_CBZ);
                endcase
                if ($urandom_range(0, 7) == 0) id_valid = 1'b0;
            end
            ex_flush = ($urandom_range(0, 15) == 0);
            step();
        end
        ex_flush = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
